// File: rtl/fifo_wr_arb_if.sv
// Shared write-port bundle between the requesters, the FIFO write side and fifo_wr_arb.
// The arbiter side uses modport master; the requester/FIFO side uses modport slave.
interface fifo_wr_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          w_full;
  logic                          w_inc;
  logic [DATA_WIDTH-1:0]         w_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;

  modport master (
    input  req_valid, req_data, req_last, w_full,
    output req_ready, w_inc, w_wdata, gnt, busy
  );

  modport slave (
    output req_valid, req_data, req_last, w_full,
    input  req_ready, w_inc, w_wdata, gnt, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-locking arbiter for the async FIFO write port (w_clk domain).
// Optional FIFO_ARB_MAXBURST_EN caps each grant at MAX_BURST beats.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic          w_clk,
  input  logic          w_rstn,
  fifo_wr_arb_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  genvar gi;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("fifo_wr_arb: NUM_REQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
      $error("fifo_wr_arb: MAX_BURST must be in 1..255");
    end
  endgenerate

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic               busy_reg;
  // Round-robin pointer kept one-hot: bit i set means search starts at requester i.
  logic [NUM_REQ-1:0] rr_ptr_reg;
  logic [7:0]         beat_cnt_reg;

  logic [NUM_REQ-1:0] prio_mask;
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] masked_low;
  logic [NUM_REQ-1:0] any_low;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] rr_ptr_next;

  logic [DATA_WIDTH-1:0] data_terms [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_chain [NUM_REQ+1];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  in_lock;
  logic                  accept;
  logic                  burst_hit;
  logic                  rel_now;
  logic [7:0]            beat_cnt_inc;

  // Requesters at or above the pointer get first pick; wrap to the lowest valid otherwise.
  assign prio_mask  = ~(rr_ptr_reg - NUM_REQ'(1));
  assign masked_req = bus.req_valid & prio_mask;
  assign masked_low = masked_req & (~masked_req + NUM_REQ'(1));
  assign any_low    = bus.req_valid & (~bus.req_valid + NUM_REQ'(1));
  assign win_oh     = (|masked_req) ? masked_low : any_low;

  assign rr_ptr_next = {gnt_reg[NUM_REQ-2:0], gnt_reg[NUM_REQ-1]};

  assign data_chain[0] = '0;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_data_mux
      assign data_terms[gi]   = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_reg[gi]}};
      assign data_chain[gi+1] = data_chain[gi] | data_terms[gi];
    end
  endgenerate

  assign sel_data  = data_chain[NUM_REQ];
  assign sel_valid = |(bus.req_valid & gnt_reg);
  assign sel_last  = |(bus.req_last & gnt_reg);

  assign in_lock      = (state_reg == LOCK);
  assign accept       = in_lock && sel_valid && !bus.w_full;
  assign beat_cnt_inc = beat_cnt_reg + 8'd1;

`ifdef FIFO_ARB_MAXBURST_EN
  assign burst_hit = (beat_cnt_inc == 8'(MAX_BURST));
`else
  assign burst_hit = 1'b0;
`endif

  assign rel_now = accept && (sel_last || burst_hit);

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      rr_ptr_reg   <= NUM_REQ'(1);
      beat_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt_reg   <= win_oh;
            busy_reg  <= 1'b1;
            state_reg <= LOCK;
          end
        end
        LOCK: begin
          if (rel_now) begin
            gnt_reg      <= '0;
            busy_reg     <= 1'b0;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= 8'd0;
            state_reg    <= IDLE;
          end else if (accept) begin
            beat_cnt_reg <= beat_cnt_inc;
          end
        end
        default: begin
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Write lands in the FIFO on the same edge the beat is accepted.
  assign bus.w_inc     = accept;
  assign bus.w_wdata   = accept ? sel_data : '0;
  assign bus.req_ready = (in_lock && !bus.w_full) ? gnt_reg : '0;
  assign bus.gnt       = gnt_reg;
  assign bus.busy      = busy_reg;

endmodule
